// File: rtl/hwgen_player_pkg.sv
// Shared definitions for the hwgen record player: header wire layout, player
// state encoding, the 64-bit stream beat struct and the last-beat strobe helper.
package hwgen_player_pkg;

  localparam int unsigned CLOCK_FREQ_HZ        = 156_250_000;
  localparam logic [15:0] HWGEN_MAGIC_NUMBER_C = 16'h6969;

  // hwgen_hdr_t wire layout: {ifg[31:0], orig_len[15:0], magic[15:0]}
  localparam int HWGEN_MAGIC_LSB = 0;
  localparam int HWGEN_LEN_LSB   = 16;
  localparam int HWGEN_IFG_LSB   = 32;

  typedef enum logic [1:0] {
    HDR,
    PAYLOAD,
    GAP,
    DROP
  } hwgen_player_state_t;

  typedef struct packed {
    logic [63:0] tdata;
    logic [7:0]  tstrb;
    logic        tlast;
  } hwgen64_axis_t;

  // Strobe of the final beat from orig_len[2:0]; a whole final word is 0xFF.
  function automatic logic [7:0] hwgen_last_strb(input logic [2:0] rem);
    return (rem == 3'd0) ? 8'hFF : 8'((9'd1 << rem) - 9'd1);
  endfunction

endpackage

// File: rtl/hwgen_gap_counter.sv
// Loadable down-counter used to time inter-frame gaps; done flags the final
// counted cycle so the owner can leave on the following edge.
module hwgen_gap_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign done = (count_q == {{(WIDTH-1){1'b0}}, 1'b1});

endmodule

// File: rtl/hwgen_player.sv
// Strips hwgen record headers and replays the payload on an AXI4-Stream with
// exact tlast/tstrb from orig_len, then idles for the record's inter-frame gap.
module hwgen_player
  import hwgen_player_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tstrb,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic [CNT_WIDTH-1:0]    pkt_count,
  output logic [CNT_WIDTH-1:0]    err_count,
  output logic                    busy
);

  generate
    if (DATA_WIDTH != 64) begin : g_bad_width
      $error("hwgen_player supports DATA_WIDTH = 64 only");
    end
  endgenerate

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  hwgen_player_state_t state_q, next_state;

  logic [13:0]          beats_left_q;
  logic [7:0]           last_strb_q;
  logic [31:0]          ifg_q;
  logic                 ifg_valid_q;
  logic [CNT_WIDTH-1:0] pkt_count_q, err_count_q;

  // Header field decode (only meaningful while in HDR).
  logic [15:0] hdr_magic, hdr_len;
  logic [31:0] hdr_ifg;
  logic [16:0] hdr_len_round;
  logic        hdr_good, is_last;

  assign hdr_magic     = s_axis_tdata[HWGEN_MAGIC_LSB +: 16];
  assign hdr_len       = s_axis_tdata[HWGEN_LEN_LSB +: 16];
  assign hdr_ifg       = s_axis_tdata[HWGEN_IFG_LSB +: 32];
  assign hdr_len_round = {1'b0, hdr_len} + 17'd7;
  assign hdr_good      = (hdr_magic == HWGEN_MAGIC_NUMBER_C) && (hdr_len != 16'd0);
  assign is_last       = (beats_left_q == 14'd1);

  // Input strobes are not forwarded: payload strobes are rebuilt from orig_len.
  logic unused_s_strb;
  assign unused_s_strb = ^s_axis_tstrb;

  logic s_ready_c, m_valid_c, m_last_c;
  logic [7:0] m_strb_c;
  logic hdr_accept, pay_hs, pkt_inc, err_inc, gap_load, gap_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= HDR;
    end else begin
      state_q <= next_state;
    end
  end

  // A beat transfers on a cycle where valid and ready are both high at the
  // clock edge; in PAYLOAD the two handshakes are the same event, since the
  // input is stalled exactly when the output is.
  always_comb begin
    next_state = state_q;
    s_ready_c  = 1'b0;
    m_valid_c  = 1'b0;
    m_last_c   = 1'b0;
    m_strb_c   = 8'hFF;
    hdr_accept = 1'b0;
    pay_hs     = 1'b0;
    pkt_inc    = 1'b0;
    err_inc    = 1'b0;
    gap_load   = 1'b0;
    case (state_q)
      HDR: begin
        s_ready_c = enable;
        if (s_axis_tvalid && enable) begin
          hdr_accept = 1'b1;
          if (hdr_good) begin
            next_state = PAYLOAD;
          end else begin
            err_inc = 1'b1;
            if (!s_axis_tlast) next_state = DROP;
          end
        end
      end
      PAYLOAD: begin
        s_ready_c = m_axis_tready;
        m_valid_c = s_axis_tvalid;
        m_last_c  = is_last || s_axis_tlast;
        m_strb_c  = is_last ? last_strb_q : 8'hFF;
        if (s_axis_tvalid && m_axis_tready) begin
          pay_hs = 1'b1;
          if (is_last || s_axis_tlast) begin
            pkt_inc = 1'b1;
            err_inc = is_last != s_axis_tlast;
            if (is_last && !s_axis_tlast) begin
              next_state = DROP;
            end else if (ifg_q != 32'd0) begin
              next_state = GAP;
              gap_load   = 1'b1;
            end else begin
              next_state = HDR;
            end
          end
        end
      end
      DROP: begin
        s_ready_c = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          if (ifg_valid_q && (ifg_q != 32'd0)) begin
            next_state = GAP;
            gap_load   = 1'b1;
          end else begin
            next_state = HDR;
          end
        end
      end
      GAP: begin
        if (gap_done) next_state = HDR;
      end
      default: next_state = HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beats_left_q <= '0;
      last_strb_q  <= 8'hFF;
      ifg_q        <= '0;
      ifg_valid_q  <= 1'b0;
      pkt_count_q  <= '0;
      err_count_q  <= '0;
    end else begin
      if (hdr_accept) begin
        ifg_valid_q <= hdr_good;
        if (hdr_good) begin
          beats_left_q <= hdr_len_round[16:3];
          last_strb_q  <= hwgen_last_strb(hdr_len[2:0]);
          ifg_q        <= hdr_ifg;
        end
      end
      if (pay_hs) beats_left_q <= beats_left_q - 14'd1;
      if (pkt_inc) pkt_count_q <= sat_inc(pkt_count_q);
      if (err_inc) err_count_q <= sat_inc(err_count_q);
    end
  end

  hwgen_gap_counter #(.WIDTH(32)) u_gap (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (gap_load),
    .load_val (ifg_q),
    .dec      (state_q == GAP),
    .done     (gap_done)
  );

  // Handshake outputs are forced low during reset so a truncated packet never
  // shows a stray beat in the reset cycle.
  assign s_axis_tready = rst_n & s_ready_c;
  assign m_axis_tvalid = rst_n & m_valid_c;
  assign m_axis_tlast  = rst_n & m_last_c;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tstrb  = m_strb_c;
  assign pkt_count     = pkt_count_q;
  assign err_count     = err_count_q;
  assign busy          = (state_q != HDR);

endmodule

// File: tb/tb_hwgen_player.sv
// Bench for hwgen_player: directed records from the test plan plus randomized
// records, checked against a record-level model and an expected-beat queue.
`timescale 1ns/1ps
module tb_hwgen_player;
  import hwgen_player_pkg::*;

  localparam int BW = $bits(hwgen64_axis_t);

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic [63:0] s_axis_tdata = '0;
  logic [7:0]  s_axis_tstrb = '0;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tstrb;
  logic [31:0] pkt_count, err_count;
  logic        busy;

  always #3.2 clk = ~clk;

  hwgen_player #(.DATA_WIDTH(64), .CNT_WIDTH(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tstrb  (s_axis_tstrb),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .pkt_count     (pkt_count),
    .err_count     (err_count),
    .busy          (busy)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [BW-1:0] exp_q[$];
  hwgen64_axis_t in_q[$];
  int exp_pkt = 0;
  int exp_err = 0;
  int cyc = 0;
  int lows = 0;
  int out_beats = 0;
  int hs_q[$];
  logic [7:0] last_out_strb = '0;
  bit rand_ready = 1'b0;
  hwgen64_axis_t mon_e;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] strb_for(input int nbytes);
    logic [7:0] s;
    s = '0;
    for (int k = 0; k < nbytes; k++) s[k] = 1'b1;
    return s;
  endfunction

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (rst_n && s_axis_tvalid && s_axis_tready) hs_q.push_back(cyc);
    if (rst_n && !s_axis_tready) lows++;
    if (rst_n && m_axis_tvalid && m_axis_tready) begin
      out_beats++;
      if (m_axis_tlast) last_out_strb = m_axis_tstrb;
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_data", m_axis_tdata, mon_e.tdata);
        check("out_strb", 64'(m_axis_tstrb), 64'(mon_e.tstrb));
        check("out_last", 64'(m_axis_tlast), 64'(mon_e.tlast));
      end
    end
  end

  // Downstream ready: solid high or random toggling.
  initial forever begin
    @(posedge clk);
    #1;
    m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- reference model ----------------
  // Builds the input beats of one record and the output beats / counter
  // effects the record must produce.
  task automatic build_record(input int len, input int ifg, input logic [15:0] magic,
                              input bit hdr_last, input int junk, input int early_at,
                              input int extra);
    hwgen64_axis_t b, o;
    int beats, n_in;
    beats = (len + 7) / 8;
    b.tdata = {32'(ifg), 16'(len), magic};
    b.tstrb = 8'($urandom);
    b.tlast = hdr_last;
    in_q.push_back(b);
    if (magic != HWGEN_MAGIC_NUMBER_C || len == 0) begin
      exp_err++;
      if (!hdr_last) begin
        for (int j = 1; j <= junk; j++) begin
          b.tdata = {$urandom, $urandom};
          b.tstrb = 8'($urandom);
          b.tlast = (j == junk);
          in_q.push_back(b);
        end
      end
    end else begin
      n_in = (early_at != 0) ? early_at : beats + extra;
      for (int i = 1; i <= n_in; i++) begin
        b.tdata = {$urandom, $urandom};
        b.tstrb = 8'($urandom);
        b.tlast = (i == n_in);
        in_q.push_back(b);
        if (i <= beats) begin
          o.tdata = b.tdata;
          o.tstrb = (i == beats) ? strb_for(len - 8 * (beats - 1)) : 8'hFF;
          o.tlast = (i == beats) || (i == n_in);
          exp_q.push_back(o);
        end
      end
      exp_pkt++;
      if (early_at != 0 || extra != 0) exp_err++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_beats(input bit gaps, input int max_beats);
    hwgen64_axis_t b;
    int n, sent;
    sent = 0;
    while (in_q.size() > 0 && sent < max_beats) begin
      b = in_q.pop_front();
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_axis_tvalid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = b.tdata;
      s_axis_tstrb  = b.tstrb;
      s_axis_tlast  = b.tlast;
      n = 0;
      forever begin
        @(negedge clk);
        if (s_axis_tready || n >= 5000) break;
        n++;
      end
      if (n >= 5000) begin
        check("send_timeout", 64'd0, 64'd1);
        in_q.delete();
      end
      @(posedge clk);
      #1;
      sent++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic drain(input int ifg);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      check("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    repeat (ifg + 3) @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_pkt"}, 64'(pkt_count), 64'(exp_pkt));
    check({tag, "_err"}, 64'(err_count), 64'(exp_err));
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    in_q.delete();
    exp_pkt = 0;
    exp_err = 0;
    @(negedge clk);
    check("rst_s_ready", 64'(s_axis_tready), 64'd0);
    check("rst_m_valid", 64'(m_axis_tvalid), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  int r_len, r_ifg, r_kind, r_beats;

  initial begin
    enable = 1'b1;
    @(posedge clk);
    #1;
    do_reset();
    check_counters("reset");
    check("reset_m_last", 64'(m_axis_tlast), 64'd0);

    // 64-byte record with ifg=3
    hs_q.delete(); lows = 0; out_beats = 0;
    build_record(64, 3, HWGEN_MAGIC_NUMBER_C, 1'b0, 0, 0, 0);
    send_beats(1'b0, 1000);
    drain(3);
    check("t1_beats", 64'(out_beats), 64'd8);
    check("t1_last_strb", 64'(last_out_strb), 64'hFF);
    check("t1_gap_cycles", 64'(lows), 64'd3);
    check("t1_hs_count", 64'(hs_q.size()), 64'd9);
    if (hs_q.size() >= 2) check("t1_hdr_to_payload", 64'(hs_q[1] - hs_q[0]), 64'd1);
    check_counters("t1");

    // two back-to-back 61-byte records, ifg=0
    hs_q.delete(); out_beats = 0;
    build_record(61, 0, HWGEN_MAGIC_NUMBER_C, 1'b0, 0, 0, 0);
    build_record(61, 0, HWGEN_MAGIC_NUMBER_C, 1'b0, 0, 0, 0);
    send_beats(1'b0, 1000);
    drain(0);
    check("t2_beats", 64'(out_beats), 64'd16);
    check("t2_last_strb", 64'(last_out_strb), 64'h1F);
    check("t2_hs_count", 64'(hs_q.size()), 64'd18);
    if (hs_q.size() >= 10) check("t2_back_to_back", 64'(hs_q[9] - hs_q[8]), 64'd1);
    check_counters("t2");

    // bad magic + 4 junk beats, then a 1-byte record
    out_beats = 0;
    build_record(8, 0, 16'h6968, 1'b0, 4, 0, 0);
    build_record(1, 0, HWGEN_MAGIC_NUMBER_C, 1'b0, 0, 0, 0);
    send_beats(1'b0, 1000);
    drain(0);
    check("t3_beats", 64'(out_beats), 64'd1);
    check("t3_last_strb", 64'(last_out_strb), 64'h01);
    check_counters("t3");

    // early input tlast on beat 3 of 8
    out_beats = 0;
    build_record(64, 0, HWGEN_MAGIC_NUMBER_C, 1'b0, 0, 3, 0);
    send_beats(1'b0, 1000);
    drain(0);
    check("t4_beats", 64'(out_beats), 64'd3);
    check("t4_last_strb", 64'(last_out_strb), 64'hFF);
    check_counters("t4");

    // missing input tlast: one extra beat dropped, then the ifg still applies
    lows = 0; out_beats = 0;
    build_record(16, 2, HWGEN_MAGIC_NUMBER_C, 1'b0, 0, 0, 1);
    send_beats(1'b0, 1000);
    drain(2);
    check("t4b_beats", 64'(out_beats), 64'd2);
    check("t4b_gap_cycles", 64'(lows), 64'd2);
    check_counters("t4b");

    // zero-length header carrying tlast, then a good record
    build_record(0, 0, HWGEN_MAGIC_NUMBER_C, 1'b1, 0, 0, 0);
    build_record(9, 0, HWGEN_MAGIC_NUMBER_C, 1'b0, 0, 0, 0);
    send_beats(1'b0, 1000);
    drain(0);
    check("t4c_last_strb", 64'(last_out_strb), 64'h01);
    check_counters("t4c");

    // enable low in HDR holds off a pending header
    enable = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = {32'd0, 16'd8, HWGEN_MAGIC_NUMBER_C};
    repeat (3) @(negedge clk);
    check("en_s_ready", 64'(s_axis_tready), 64'd0);
    check("en_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    enable = 1'b1;
    check_counters("en");

    // 1500-byte record under random backpressure
    rand_ready = 1'b1; out_beats = 0;
    build_record(1500, 0, HWGEN_MAGIC_NUMBER_C, 1'b0, 0, 0, 0);
    send_beats(1'b1, 1000);
    drain(0);
    rand_ready = 1'b0;
    check("t5_beats", 64'(out_beats), 64'd188);
    check("t5_last_strb", 64'(last_out_strb), 64'h0F);
    check_counters("t5");

    // reset during beat 5 of 8
    build_record(64, 0, HWGEN_MAGIC_NUMBER_C, 1'b0, 0, 0, 0);
    send_beats(1'b0, 5);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = in_q[0].tdata;
    s_axis_tlast  = 1'b0;
    rst_n = 1'b0;
    exp_q.delete(); in_q.delete();
    exp_pkt = 0; exp_err = 0;
    @(negedge clk);
    check("t6_rst_m_valid", 64'(m_axis_tvalid), 64'd0);
    check("t6_rst_s_ready", 64'(s_axis_tready), 64'd0);
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_m_valid", 64'(m_axis_tvalid), 64'd0);
    check_counters("t6_after_rst");
    @(posedge clk);
    #1;
    out_beats = 0;
    build_record(20, 1, HWGEN_MAGIC_NUMBER_C, 1'b0, 0, 0, 0);
    send_beats(1'b0, 1000);
    drain(1);
    check("t6_beats", 64'(out_beats), 64'd3);
    check("t6_last_strb", 64'(last_out_strb), 64'h0F);
    check_counters("t6");

    // randomized records
    rand_ready = 1'b1;
    for (int r = 0; r < 25; r++) begin
      r_len   = $urandom_range(1, 200);
      r_ifg   = $urandom_range(0, 5);
      r_kind  = $urandom_range(0, 5);
      r_beats = (r_len + 7) / 8;
      if (r_kind == 3)
        build_record(r_len, r_ifg, HWGEN_MAGIC_NUMBER_C ^ 16'($urandom_range(1, 65535)),
                     1'b0, $urandom_range(1, 3), 0, 0);
      else if (r_kind == 4 && r_beats > 1)
        build_record(r_len, r_ifg, HWGEN_MAGIC_NUMBER_C, 1'b0, 0,
                     $urandom_range(1, r_beats - 1), 0);
      else if (r_kind == 5)
        build_record(r_len, r_ifg, HWGEN_MAGIC_NUMBER_C, 1'b0, 0, 0, $urandom_range(1, 2));
      else
        build_record(r_len, r_ifg, HWGEN_MAGIC_NUMBER_C, 1'b0, 0, 0, 0);
      send_beats(1'b1, 1000);
      drain(r_ifg);
      check_counters("rand");
    end
    rand_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hwgen_player.md
# hwgen_player

Consumes a hwgen-encoded AXI4-Stream: each record is one header beat followed by packet payload beats. The block strips the header, replays the payload on an output AXI4-Stream with exact `tlast`/`tstrb` derived from `orig_len`, and then holds off for `ifg` clock cycles before the next record. It sits between the hwgen record source (DMA/FIFO) and the MAC TX interface, on the 156.25 MHz clock.

## Interface
Parameters:
- `DATA_WIDTH`, 64, stream width in bits; only 64 is supported, and any other value fails elaboration.
- `CNT_WIDTH`, 32, width of the statistics counters.

Ports:
- `clk` in 1: single clock, 156.25 MHz (`CLOCK_FREQ_HZ`).
- `rst_n` in 1: synchronous, active-low reset.
- `enable` in 1: when low, the block finishes the current record and then idles in `HDR`.
- `s_axis_tvalid`, `s_axis_tready`, `s_axis_tlast`: in, out, in; 1 bit each; input record stream handshake.
- `s_axis_tdata` in 64 and `s_axis_tstrb` in 8: input record data and byte strobes.
- `m_axis_tvalid`, `m_axis_tready`, `m_axis_tlast`: out, in, out; 1 bit each; output packet handshake.
- `m_axis_tdata` out 64 and `m_axis_tstrb` out 8: output packet data and byte strobes.
- `pkt_count` out CNT_WIDTH: count of packets replayed.
- `err_count` out CNT_WIDTH: count of errored records.
- `busy` out 1: high when the state is not `HDR`.

## Operation
- Header beat layout:
  - `[15:0]` = magic, which must equal `HWGEN_MAGIC_NUMBER_C` (0x6969).
  - `[31:16]` = `orig_len` in bytes.
  - `[63:32]` = `ifg` in clock cycles.
  - Header `tstrb` is ignored.
- States: `HDR`, `PAYLOAD`, `GAP`, `DROP`.
- `HDR`:
  - `s_axis_tready` = `enable`.
  - On a header accept with good magic and `orig_len` != 0: latch `beats_left` = ceil(`orig_len`/8), latch `last_strb` from `orig_len[2:0]` (0 means 0xFF, otherwise (1<<n)-1), latch `ifg`, and go to `PAYLOAD`.
  - On bad magic or `orig_len` == 0: `err_count`++. If `s_axis_tlast` is set on the header beat, stay in `HDR`; otherwise go to `DROP`.
- `PAYLOAD`:
  - Pass-through: `m_axis_tvalid` = `s_axis_tvalid`, `s_axis_tready` = `m_axis_tready`, and `tdata` passes through unchanged.
  - `m_axis_tstrb` = 0xFF, except on the final beat where it is `last_strb`.
  - `m_axis_tlast` = (`beats_left` == 1) OR `s_axis_tlast`.
  - On each handshake, `beats_left` decrements.
  - On the final beat handshake: `pkt_count`++. Go to `GAP` if `ifg` != 0, else go to `HDR`.
  - Early input `tlast` (`beats_left` > 1): emit `m_axis_tlast` with `tstrb` = 0xFF, `err_count`++, `pkt_count`++, then proceed to `GAP`/`HDR` as normal.
  - Missing input `tlast` when `beats_left` == 1: the output still ends normally, `err_count`++, and the next state is `DROP` instead of `GAP`/`HDR`.
- `DROP`: `s_axis_tready` = 1 and `m_axis_tvalid` = 0. On an input handshake with `tlast`, go to `GAP` if a valid `ifg` was latched for this record, else go to `HDR`.
- `GAP`:
  - Both readies and both valids are 0.
  - A down-counter is loaded with `ifg` on entry and decrements each cycle.
  - Leave to `HDR` on the cycle after the counter reads 1. `GAP` therefore lasts exactly `ifg` cycles.
- Counters saturate at all-ones.

## Timing
- Reset (`rst_n` low at a clock edge):
  - State = `HDR`.
  - `pkt_count` = 0, `err_count` = 0.
  - `m_axis_tvalid` = 0, `m_axis_tlast` = 0, `s_axis_tready` = 0 in the reset cycle; `busy` = 0.
  - Reset mid-packet truncates the output with no `tlast`; downstream is reset together with this block.
- The payload path is zero-latency and combinational from `s_axis` to `m_axis`. All state, counters and strobe selection are registered.
- The header beat produces no output beat.
- The first payload beat may be accepted in the cycle after the header handshake.
- Record throughput with no backpressure: one header cycle + ceil(len/8) payload cycles + `ifg` cycles.
- `m_axis_tvalid` must not drop once asserted until the handshake completes. This holds provided the source obeys AXI; the block adds no retraction.
- `enable` is sampled only in `HDR`. Deasserting it mid-record has no effect until the record ends.

## Structure
- Add to the shared `definitions` package:
  - `hwgen_hdr_t` wire-layout localparams: `HWGEN_MAGIC_LSB` = 0, `HWGEN_LEN_LSB` = 16, `HWGEN_IFG_LSB` = 32.
  - The player state enum `hwgen_player_state_t`.
- Use the existing `AXI4_STREAM_STRUCT_DEF(hwgen64, 64)` typedef for bench-side modelling.
- One sub-module, `hwgen_gap_counter`: loadable 32-bit down-counter with a `done` output, reused by the future timestamp-paced player.

## Test plan
- Header {ifg=3, len=64, magic=0x6969} + 8 beats, last with `tlast`, `m_axis_tready`=1 -> 8 output beats; the 8th has `tlast`=1 and `tstrb`=0xFF; `s_axis_tready` is low for exactly 3 cycles; `pkt_count`=1.
- len=61, ifg=0, two back-to-back records -> 8 beats with last `tstrb`=0x1F; the second header is accepted the cycle after the first record's final beat; `pkt_count`=2.
- Magic 0x6968, followed by 4 junk beats ending in `tlast`, then a good 1-byte record -> junk dropped; `err_count`=1; one output beat with `tstrb`=0x01 and `tlast`=1.
- len=64 but input `tlast` on beat 3 -> output `tlast` on beat 3 with `tstrb`=0xFF; `err_count`=1; `pkt_count`=1.
- Random `m_axis_tready` toggling on a 1500-byte record -> 188 beats with data in order; the last beat has `tstrb`=0x0F; no beat duplicated or lost.
- `rst_n` low during beat 5 of 8 -> next cycle `m_axis_tvalid`=0 and counters=0; the next good record replays correctly.
